text_console: RTL and testbench

- Character-stream terminal controller that owns the VRAM write port (write_ce/row/col/data) of the 100 x 30 text display.
- Accepts bytes over a valid/ready handshake and tracks a cursor. Writes printable characters, handles CR/LF/BS, wraps at end of line.
- Scrolls by advancing a circular row offset (scroll_row) and blanking the recycled line. The display read path adds scroll_row (mod ROWS) to its row before addressing VRAM.
- Clears the whole screen after reset.

---
 rtl/text_console.sv | 170 +++++++++++++++++
 tb/tb_text_console.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-stream terminal controller for a COLS x ROWS text display.
// Owns the VRAM write port, tracks the cursor and scrolls via a circular row offset.
module text_console #(
  parameter int          COLS  = 100,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20,
  localparam int         COL_W = $clog2(COLS),
  localparam int         ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             write_ce,
  output logic [ROW_W-1:0] write_row,
  output logic [COL_W-1:0] write_col,
  output logic [7:0]       write_data,
  output logic [ROW_W-1:0] scroll_row,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  localparam logic [ROW_W:0]   ROWS_X   = ROWS[ROW_W:0];
  localparam logic [ROW_W-1:0] LAST_ROW = ROWS_X[ROW_W-1:0] - 1'b1;
  localparam logic [COL_W:0]   COLS_X   = COLS[COL_W:0];
  localparam logic [COL_W-1:0] LAST_COL = COLS_X[COL_W-1:0] - 1'b1;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

  state_t           state, state_d;
  logic [ROW_W-1:0] clr_row, clr_row_d;
  logic [COL_W-1:0] clr_col, clr_col_d;
  logic [ROW_W-1:0] cursor_row_d, scroll_row_d;
  logic [COL_W-1:0] cursor_col_d;
  logic             write_ce_d;
  logic [ROW_W-1:0] write_row_d;
  logic [COL_W-1:0] write_col_d;
  logic [7:0]       write_data_d;
  logic             newline;

  // Logical-to-physical row mapping without needing a modulo operator.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                input logic [ROW_W-1:0] offs);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, offs};
    if (sum >= ROWS_X) sum = sum - ROWS_X;
    return sum[ROW_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ALL;
      clr_row    <= '0;
      clr_col    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      scroll_row <= '0;
      write_ce   <= 1'b0;
      write_row  <= '0;
      write_col  <= '0;
      write_data <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_d;
      clr_row    <= clr_row_d;
      clr_col    <= clr_col_d;
      cursor_row <= cursor_row_d;
      cursor_col <= cursor_col_d;
      scroll_row <= scroll_row_d;
      write_ce   <= write_ce_d;
      write_row  <= write_row_d;
      write_col  <= write_col_d;
      write_data <= write_data_d;
      in_ready   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state;
    clr_row_d    = clr_row;
    clr_col_d    = clr_col;
    cursor_row_d = cursor_row;
    cursor_col_d = cursor_col;
    scroll_row_d = scroll_row;
    write_ce_d   = 1'b0;
    write_row_d  = write_row;
    write_col_d  = write_col;
    write_data_d = write_data;
    newline      = 1'b0;

    case (state)
      CLEAR_ALL: begin
        write_ce_d   = 1'b1;
        write_row_d  = clr_row;
        write_col_d  = clr_col;
        write_data_d = BLANK;
        if (clr_col == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row == LAST_ROW) begin
            clr_row_d = '0;
            state_d   = IDLE;
          end else begin
            clr_row_d = clr_row + 1'b1;
          end
        end else begin
          clr_col_d = clr_col + 1'b1;
        end
      end

      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_char >= 8'h20 && in_char != 8'h7F) begin
            write_ce_d   = 1'b1;
            write_row_d  = phys_row(cursor_row, scroll_row);
            write_col_d  = cursor_col;
            write_data_d = in_char;
            if (cursor_col == LAST_COL) begin
              cursor_col_d = '0;
              newline      = 1'b1;
            end else begin
              cursor_col_d = cursor_col + 1'b1;
            end
          end else if (in_char == 8'h0D) begin
            cursor_col_d = '0;
          end else if (in_char == 8'h0A) begin
            newline = 1'b1;
          end else if (in_char == 8'h08) begin
            if (cursor_col != '0) cursor_col_d = cursor_col - 1'b1;
          end

          // At the bottom line the oldest physical row is recycled as the new bottom line.
          if (newline) begin
            if (cursor_row != LAST_ROW) begin
              cursor_row_d = cursor_row + 1'b1;
            end else begin
              clr_row_d    = scroll_row;
              clr_col_d    = '0;
              scroll_row_d = (scroll_row == LAST_ROW) ? '0 : scroll_row + 1'b1;
              state_d      = CLEAR_LINE;
            end
          end
        end
      end

      CLEAR_LINE: begin
        write_ce_d   = 1'b1;
        write_row_d  = clr_row;
        write_col_d  = clr_col;
        write_data_d = BLANK;
        if (clr_col == LAST_COL) begin
          clr_col_d = '0;
          state_d   = IDLE;
        end else begin
          clr_col_d = clr_col + 1'b1;
        end
      end

      default: state_d = CLEAR_ALL;
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed scenarios plus random byte stream
// compared against a cursor/scroll reference model and an expected-write queue.
module tb_text_console;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       write_ce;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_data;
  logic [4:0] scroll_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;
  int writeCount = 0;

  int mRow, mCol, mScroll;
  logic [19:0] expQ[$];

  text_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .write_ce   (write_ce),
    .write_row  (write_row),
    .write_col  (write_col),
    .write_data (write_data),
    .scroll_row (scroll_row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushFullClear();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 100; c++)
        expQ.push_back({5'(r), 7'(c), 8'h20});
  endtask

  // Reference model: the screen rules applied directly with modulo arithmetic.
  task automatic modelAccept(input logic [7:0] b);
    bit nl = 0;
    if (b >= 8'h20 && b != 8'h7F) begin
      expQ.push_back({5'((mRow + mScroll) % 30), 7'(mCol), b});
      if (mCol < 99) mCol++;
      else begin mCol = 0; nl = 1; end
    end else if (b == 8'h0D) mCol = 0;
    else if (b == 8'h0A) nl = 1;
    else if (b == 8'h08) begin
      if (mCol > 0) mCol--;
    end
    if (nl) begin
      if (mRow < 29) mRow++;
      else begin
        for (int c = 0; c < 100; c++) expQ.push_back({5'(mScroll), 7'(c), 8'h20});
        mScroll = (mScroll + 1) % 30;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && write_ce) begin
      writeCount++;
      if (expQ.size() == 0) checkOutput("unexpectedWrite", 32'(write_ce), 32'd0);
      else checkOutput("writeCell", 32'({write_row, write_col, write_data}), 32'(expQ.pop_front()));
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, ".row"}, 32'(cursor_row), 32'(mRow));
    checkOutput({tag, ".col"}, 32'(cursor_col), 32'(mCol));
    checkOutput({tag, ".scroll"}, 32'(scroll_row), 32'(mScroll));
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt = 0;
    while (!in_ready && waitCnt < 5000) begin @(negedge clk); #1; waitCnt++; end
    if (!in_ready) begin
      checkOutput("sendReady", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_char  = b;
    modelAccept(b);
    @(negedge clk); #1;
    in_valid = 1'b0;
    checkCursor("cursor");
  endtask

  task automatic waitIdle();
    int waitCnt = 0;
    while (!in_ready && waitCnt < 5000) begin @(negedge clk); #1; waitCnt++; end
    checkOutput("idleReached", 32'(in_ready), 32'd1);
  endtask

  task automatic checkDrained(input string tag);
    waitIdle();
    idleCycles(2);
    checkOutput({tag, ".pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkCursor(tag);
  endtask

  task automatic resetModel();
    expQ.delete();
    mRow = 0; mCol = 0; mScroll = 0;
  endtask

  initial begin
    int cnt;
    int snap;
    logic [7:0] b;
    int r;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    resetModel();
    idleCycles(3);
    checkOutput("resetReady", 32'(in_ready), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd1);
    checkOutput("resetWce", 32'(write_ce), 32'd0);
    checkCursor("resetCursor");

    pushFullClear();
    reset_n = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 5000) begin @(negedge clk); #1; cnt++; end
    checkOutput("clearAllCycles", 32'(writeCount), 32'd3000);
    checkDrained("afterClearAll");

    $display("[TB] AB CR C sequence");
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h0D);
    checkOutput("crReady", 32'(in_ready), 32'd1);
    applyStimulus(8'h43);
    checkDrained("afterABC");
    checkOutput("abcCol", 32'(cursor_col), 32'd1);

    $display("[TB] full line wrap");
    applyStimulus(8'h0D);
    for (int i = 0; i < 100; i++) applyStimulus(8'(8'h30 + (i % 40)));
    checkDrained("afterWrap");
    checkOutput("wrapRow", 32'(cursor_row), 32'd1);
    checkOutput("wrapScroll", 32'(scroll_row), 32'd0);

    $display("[TB] scroll at bottom");
    while (mRow < 29) applyStimulus(8'h0A);
    snap = writeCount;
    applyStimulus(8'h0A);
    cnt = 0;
    while (!in_ready && cnt < 1000) begin @(negedge clk); #1; cnt++; end
    checkOutput("lfReadyLow", 32'(cnt), 32'd100);
    checkDrained("afterScroll");
    checkOutput("lfClearWrites", 32'(writeCount - snap), 32'd100);
    checkOutput("lfScroll", 32'(scroll_row), 32'd1);
    checkOutput("lfRow", 32'(cursor_row), 32'd29);

    $display("[TB] scroll offset wrap");
    while (mScroll != 29) applyStimulus(8'h0A);
    applyStimulus(8'h0D);
    for (int i = 0; i < 99; i++) applyStimulus(8'h78);
    checkOutput("preWrapCol", 32'(cursor_col), 32'd99);
    applyStimulus(8'h5A);
    checkDrained("afterScrollWrap");
    checkOutput("wrapScrollZero", 32'(scroll_row), 32'd0);
    checkOutput("wrapCursorCol", 32'(cursor_col), 32'd0);

    $display("[TB] ignored bytes");
    snap = writeCount;
    applyStimulus(8'h08);
    applyStimulus(8'h07);
    applyStimulus(8'h7F);
    checkDrained("afterIgnored");
    checkOutput("ignoredWrites", 32'(writeCount - snap), 32'd0);

    $display("[TB] reset during line clear");
    applyStimulus(8'h0A);
    idleCycles(10);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midResetWce", 32'(write_ce), 32'd0);
    checkOutput("midResetReady", 32'(in_ready), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd1);
    checkOutput("midResetWrow", 32'(write_row), 32'd0);
    resetModel();
    checkCursor("midReset");
    idleCycles(2);
    snap = writeCount;
    pushFullClear();
    reset_n = 1'b1;
    checkDrained("afterReclear");
    checkOutput("reclearWrites", 32'(writeCount - snap), 32'd3000);

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycles(1);
      r = $urandom_range(0, 99);
      if (r < 70) b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(128, 255));
      else if (r < 80) b = 8'h0A;
      else if (r < 87) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else b = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom_range(0, 31));
      applyStimulus(b);
    end
    checkDrained("afterRandom");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
